// File: rtl/switch_debouncer_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
//   SW_DEBOUNCE_1MS_50MHZ : default stable-cycle count (1 ms at 50 MHz)
//   clog2_min1(n)         : counter width for a count limit of n (at least 1 bit)
package switch_debouncer_pkg;

  localparam int SW_DEBOUNCE_1MS_50MHZ = 50000;

  // Counter only needs to reach n-1, so $clog2(n) bits suffice; a limit of 1
  // still needs a 1-bit register to keep the port/vector widths legal.
  function automatic int clog2_min1(int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, debounced level
// register and registered rise/fall pulses.
//   clk, reset : system clock, async active-high reset
//   sw_raw     : asynchronous pin
//   sw_db      : debounced level
//   sw_rise    : one-cycle pulse on accepted 0->1
//   sw_fall    : one-cycle pulse on accepted 1->0
//   accept     : combinational, high in the cycle before sw_db changes
//                (lets the top register a change flag aligned with the pulses)
module switch_debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_1MS_50MHZ,
  parameter int CNT_W           = clog2_min1(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_db,
  output logic sw_rise,
  output logic sw_fall,
  output logic accept
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // The DEBOUNCE_CYCLES-th consecutive mismatching cycle is the one that
  // commits; the counter never goes past CNT_LAST.
  assign accept = (s2 != sw_db) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      sw_db   <= 1'b0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      s1      <= sw_raw;
      s2      <= s1;
      sw_rise <= accept &  s2;
      sw_fall <= accept & ~s2;
      // Any return to the current level discards the partial count.
      if (s2 == sw_db || accept) cnt <= '0;
      else                       cnt <= cnt + CNT_W'(1);
      if (accept) sw_db <= s2;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a word of slide switches for the switches PIO.
//   clk, reset : system clock (PIO clock), async active-high reset
//   sw_raw     : asynchronous switch pins, WIDTH bits
//   sw_db      : debounced word, drives PIO in_port
//   sw_rise    : per-bit one-cycle pulse on debounced 0->1
//   sw_fall    : per-bit one-cycle pulse on debounced 1->0
//   sw_changed : one-cycle pulse when any bit rose or fell, same cycle as pulses
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_1MS_50MHZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam int CNT_W = clog2_min1(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] accept;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      switch_debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_bit (
        .clk     (clk),
        .reset   (reset),
        .sw_raw  (sw_raw[i]),
        .sw_db   (sw_db[i]),
        .sw_rise (sw_rise[i]),
        .sw_fall (sw_fall[i]),
        .accept  (accept[i])
      );
    end
  endgenerate

  // Registered from the per-bit accept terms so it lines up with the pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sw_changed <= 1'b0;
    else       sw_changed <= |accept;
  end

endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

  localparam int W  = 10;
  localparam int DC = 8;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] raw_a = '0;
  logic [W-1:0] raw_b = '0;

  logic [W-1:0] db_a, rise_a, fall_a;
  logic         chg_a;
  logic [W-1:0] db_b, rise_b, fall_b;
  logic         chg_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut_a (
    .clk(clk), .reset(reset), .sw_raw(raw_a),
    .sw_db(db_a), .sw_rise(rise_a), .sw_fall(fall_a), .sw_changed(chg_a)
  );

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .sw_raw(raw_b),
    .sw_db(db_b), .sw_rise(rise_b), .sw_fall(fall_b), .sw_changed(chg_b)
  );

  // Reference for dut_a: pins are seen two samples late; a bit takes the
  // delayed pin value once that value has been seen DC samples in a row and
  // differs from the current debounced level.
  logic [W-1:0] m_p1, m_p2, m_last, m_db, m_rise, m_fall;
  logic         m_chg;
  int           m_run [W];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_p1 <= '0; m_p2 <= '0; m_last <= '0; m_db <= '0;
      m_rise <= '0; m_fall <= '0; m_chg <= 1'b0;
      for (int i = 0; i < W; i++) m_run[i] <= 0;
    end else begin
      logic [W-1:0] acc;
      int r;
      acc = '0;
      for (int i = 0; i < W; i++) begin
        r = (m_p2[i] == m_last[i]) ? m_run[i] + 1 : 1;
        m_run[i] <= r;
        if (m_p2[i] != m_db[i] && r >= DC) acc[i] = 1'b1;
      end
      m_last <= m_p2;
      m_db   <= m_db ^ acc;
      m_rise <= acc & m_p2;
      m_fall <= acc & ~m_p2;
      m_chg  <= |acc;
      m_p2   <= m_p1;
      m_p1   <= raw_a;
    end
  end

  // Hold reset two edges, release just after an edge; the next edge is the
  // first one that samples the pins.
  task automatic apply_reset(input logic [W-1:0] ra);
    raw_a = ra; raw_b = '0; reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    raw_a = 10'h3FF; raw_b = 10'h3FF; reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({db_a, rise_a, fall_a, chg_a} !== '0)
      begin errors++; $display("FAIL reset_a: got db=%h rise=%h fall=%h chg=%b want all 0", db_a, rise_a, fall_a, chg_a); end
    checks++;
    if ({db_b, rise_b, fall_b, chg_b} !== '0)
      begin errors++; $display("FAIL reset_b: got db=%h rise=%h fall=%h chg=%b want all 0", db_b, rise_b, fall_b, chg_b); end
  endtask

  task automatic test_clean_rise();
    logic [W-1:0] edb, er;
    logic ec;
    apply_reset('0);
    raw_a[0] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      edb = (n >= 10) ? 10'h001 : 10'h000;
      er  = (n == 10) ? 10'h001 : 10'h000;
      ec  = (n == 10);
      checks++;
      if (db_a !== edb || rise_a !== er || fall_a !== '0 || chg_a !== ec)
        begin errors++; $display("FAIL clean_rise edge %0d: got db=%h rise=%h fall=%h chg=%b want db=%h rise=%h fall=000 chg=%b", n, db_a, rise_a, fall_a, chg_a, edb, er, ec); end
    end
  endtask

  task automatic test_bounce();
    int lvl [4] = '{1, 0, 1, 0};
    int len [4] = '{5, 2, 7, 1};
    apply_reset('0);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < len[s]; c++) begin
        raw_a[3] = lvl[s][0];
        @(posedge clk); #1;
        checks++;
        if (db_a !== '0 || chg_a !== 1'b0 || rise_a !== '0)
          begin errors++; $display("FAIL bounce_quiet seg %0d: got db=%h rise=%h chg=%b want 000/000/0", s, db_a, rise_a, chg_a); end
      end
    end
    raw_a[3] = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      @(posedge clk); #1;
      checks++;
      if (db_a !== ((n >= 10) ? 10'h008 : 10'h000) || rise_a !== ((n == 10) ? 10'h008 : 10'h000) || chg_a !== (n == 10))
        begin errors++; $display("FAIL bounce_accept edge %0d: got db=%h rise=%h chg=%b", n, db_a, rise_a, chg_a); end
    end
  endtask

  task automatic test_simultaneous();
    int pulses;
    apply_reset('0);
    raw_a = 10'h3FF;
    pulses = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      pulses += int'(chg_a);
      checks++;
      if (db_a !== ((n >= 10) ? 10'h3FF : 10'h000) || rise_a !== ((n == 10) ? 10'h3FF : 10'h000))
        begin errors++; $display("FAIL simul_rise edge %0d: got db=%h rise=%h", n, db_a, rise_a); end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL simul_rise_chg: got %0d changed pulses want 1", pulses); end
    raw_a = 10'h000;
    pulses = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      pulses += int'(chg_a);
      checks++;
      if (db_a !== ((n >= 10) ? 10'h000 : 10'h3FF) || fall_a !== ((n == 10) ? 10'h3FF : 10'h000) || rise_a !== '0)
        begin errors++; $display("FAIL simul_fall edge %0d: got db=%h fall=%h rise=%h", n, db_a, fall_a, rise_a); end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL simul_fall_chg: got %0d changed pulses want 1", pulses); end
  endtask

  task automatic test_reset_mid_count();
    apply_reset('0);
    raw_a = 10'h001;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (db_a !== 10'h001) begin errors++; $display("FAIL midrst_pre: got db=%h want 001", db_a); end
    raw_a[5] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({db_a, rise_a, fall_a, chg_a} !== '0)
      begin errors++; $display("FAIL midrst_async: got db=%h rise=%h fall=%h chg=%b want all 0", db_a, rise_a, fall_a, chg_a); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      @(posedge clk); #1;
      checks++;
      if (db_a !== ((n >= 10) ? 10'h021 : 10'h000) || rise_a !== ((n == 10) ? 10'h021 : 10'h000) || chg_a !== (n == 10))
        begin errors++; $display("FAIL midrst_after edge %0d: got db=%h rise=%h chg=%b", n, db_a, rise_a, chg_a); end
    end
  endtask

  task automatic test_powerup_high();
    int pulses;
    apply_reset(10'h2A5);
    pulses = 0;
    for (int n = 1; n <= 13; n++) begin
      @(posedge clk); #1;
      pulses += int'(chg_a);
      checks++;
      if (db_a !== ((n >= 10) ? 10'h2A5 : 10'h000) || rise_a !== ((n == 10) ? 10'h2A5 : 10'h000) || fall_a !== '0)
        begin errors++; $display("FAIL powerup edge %0d: got db=%h rise=%h fall=%h", n, db_a, rise_a, fall_a); end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL powerup_chg: got %0d changed pulses want 1", pulses); end
  endtask

  task automatic test_dc1();
    apply_reset('0);
    raw_b[9] = 1'b1;
    @(posedge clk); #1;
    raw_b[9] = 1'b0;
    for (int n = 2; n <= 6; n++) begin
      @(posedge clk); #1;
      checks++;
      if (db_b   !== ((n == 3) ? 10'h200 : 10'h000) ||
          rise_b !== ((n == 3) ? 10'h200 : 10'h000) ||
          fall_b !== ((n == 4) ? 10'h200 : 10'h000) ||
          chg_b  !== (n == 3 || n == 4))
        begin errors++; $display("FAIL dc1 edge %0d: got db=%h rise=%h fall=%h chg=%b", n, db_b, rise_b, fall_b, chg_b); end
    end
  endtask

  task automatic test_random();
    int pr;
    apply_reset(W'($urandom));
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) pr = $urandom_range(1, 24);
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, pr) == 0) raw_a[i] = ~raw_a[i];
      if (c == 2222) begin
        reset = 1'b1; #2; reset = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if ({db_a, rise_a, fall_a, chg_a} !== {m_db, m_rise, m_fall, m_chg})
        begin errors++; $display("FAIL random cycle %0d: got db=%h rise=%h fall=%h chg=%b want db=%h rise=%h fall=%h chg=%b", c, db_a, rise_a, fall_a, chg_a, m_db, m_rise, m_fall, m_chg); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_powerup_high();
    test_dc1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
